// File: rtl/riscv_fetch_pkg.sv
// Shared types and constants for the instruction-fetch front end.
// fetch_entry_t is the default 32-bit queue entry; wider configurations define their own.
package riscv_fetch_pkg;

    localparam int unsigned PC_STEP = 4;
    localparam logic [31:0] NOP     = 32'h0000_0013;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Circular buffer of fetched entries with synchronous flush and registered head outputs.
// The head register always holds the oldest entry, or zero when the buffer is empty.
module fetch_fifo
    import riscv_fetch_pkg::*;
#(
    parameter int unsigned DEPTH   = 4,
    parameter type         entry_t = fetch_entry_t
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,
    input  logic                   push,
    input  entry_t                 wdata,
    input  logic                   pop,
    output entry_t                 head,
    output logic                   valid,
    output logic [$clog2(DEPTH):0] count
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    entry_t          mem [DEPTH];
    logic [PW-1:0]   wr_ptr_q, rd_ptr_q, rd_next;
    logic [CW-1:0]   count_q, count_d;
    entry_t          head_q, head_d;
    logic            valid_q;
    logic            push_ok, pop_ok;

    assign pop_ok  = pop && (count_q != '0);
    assign push_ok = push && ((count_q != CW'(DEPTH)) || pop_ok);
    assign rd_next = rd_ptr_q + PW'(1);

    always_comb begin
        if (flush) begin
            count_d = '0;
        end else begin
            count_d = count_q + CW'(push_ok) - CW'(pop_ok);
        end
    end

    // A push lands directly in the head register when it becomes the oldest entry.
    always_comb begin
        head_d = head_q;
        if (flush || (count_d == '0)) begin
            head_d = '0;
        end else if (push_ok && ((count_q == '0) || ((count_q == CW'(1)) && pop_ok))) begin
            head_d = wdata;
        end else if (pop_ok) begin
            head_d = mem[rd_next];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            head_q   <= '0;
            valid_q  <= 1'b0;
        end else begin
            count_q <= count_d;
            head_q  <= head_d;
            valid_q <= (count_d != '0);
            if (flush) begin
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
            end else begin
                if (push_ok) wr_ptr_q <= wr_ptr_q + PW'(1);
                if (pop_ok)  rd_ptr_q <= rd_next;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok && !flush) begin
            mem[wr_ptr_q] <= wdata;
        end
    end

    assign head  = head_q;
    assign valid = valid_q;
    assign count = count_q;

endmodule

// File: rtl/fetch_queue.sv
// Instruction-fetch front end: owns the fetch PC, issues credit-limited in-order memory
// requests, buffers responses with their PCs and presents them to decode; redirect flushes.
module fetch_queue
    import riscv_fetch_pkg::*;
#(
    parameter int unsigned             ADDRESS_WIDTH = 32,
    parameter int unsigned             DATA_WIDTH    = 32,
    parameter int unsigned             DEPTH         = 4,
    parameter logic [ADDRESS_WIDTH-1:0] RESET_PC     = '0
) (
    input  logic                     clk,
    input  logic                     rst,
    output logic                     imem_req_valid,
    input  logic                     imem_req_ready,
    output logic [ADDRESS_WIDTH-1:0] imem_req_addr,
    input  logic                     imem_rsp_valid,
    input  logic [DATA_WIDTH-1:0]    imem_rsp_data,
    input  logic                     redirect,
    input  logic [ADDRESS_WIDTH-1:0] redirect_pc,
    output logic                     instr_valid,
    input  logic                     instr_ready,
    output logic [DATA_WIDTH-1:0]    instr,
    output logic [ADDRESS_WIDTH-1:0] instr_pc,
    output logic [ADDRESS_WIDTH-1:0] instr_pc_plus4
);

    localparam int unsigned CW = $clog2(DEPTH) + 1;
    localparam logic [ADDRESS_WIDTH-1:0] STEP = ADDRESS_WIDTH'(PC_STEP);

    typedef struct packed {
        logic [ADDRESS_WIDTH-1:0] pc;
        logic [DATA_WIDTH-1:0]    instr;
    } entry_t;

    logic [ADDRESS_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
    logic [ADDRESS_WIDTH-1:0] rsp_pc_q, rsp_pc_d;
    logic [CW-1:0]            inflight_q, inflight_d;
    logic [CW-1:0]            drop_q, drop_d;
    logic [CW-1:0]            count;
    logic [CW:0]              used;
    logic                     has_credit;
    logic                     accept, rsp_fire, rsp_keep, pop;
    logic [ADDRESS_WIDTH-1:0] redirect_aligned;
    entry_t                   wdata, head;

    assign used             = {1'b0, count} + {1'b0, inflight_q};
    assign has_credit       = used < (CW + 1)'(DEPTH);
    assign imem_req_valid   = rst && has_credit && !redirect;
    assign imem_req_addr    = fetch_pc_q;
    assign accept           = imem_req_valid && imem_req_ready;
    // A response with nothing outstanding is a protocol error and is ignored.
    assign rsp_fire         = imem_rsp_valid && (inflight_q != '0);
    assign rsp_keep         = rsp_fire && !redirect && (drop_q == '0);
    assign pop              = instr_valid && instr_ready;
    assign redirect_aligned = redirect_pc & ~ADDRESS_WIDTH'(3);
    assign wdata            = '{pc: rsp_pc_q, instr: imem_rsp_data};

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        rsp_pc_d   = rsp_pc_q;
        inflight_d = inflight_q;
        drop_d     = drop_q;
        if (redirect) begin
            fetch_pc_d = redirect_aligned;
            rsp_pc_d   = redirect_aligned;
            inflight_d = inflight_q - CW'(rsp_fire);
            // Every response still outstanding after a redirect belongs to the old stream.
            drop_d     = inflight_d;
        end else begin
            if (accept)   fetch_pc_d = fetch_pc_q + STEP;
            if (rsp_keep) rsp_pc_d   = rsp_pc_q + STEP;
            inflight_d = inflight_q + CW'(accept) - CW'(rsp_fire);
            if (rsp_fire && (drop_q != '0)) drop_d = drop_q - CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fetch_pc_q <= RESET_PC;
            rsp_pc_q   <= RESET_PC;
            inflight_q <= '0;
            drop_q     <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            rsp_pc_q   <= rsp_pc_d;
            inflight_q <= inflight_d;
            drop_q     <= drop_d;
        end
    end

    fetch_fifo #(
        .DEPTH   (DEPTH),
        .entry_t (entry_t)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .flush (redirect),
        .push  (rsp_keep),
        .wdata (wdata),
        .pop   (pop),
        .head  (head),
        .valid (instr_valid),
        .count (count)
    );

    assign instr          = head.instr;
    assign instr_pc       = head.pc;
    assign instr_pc_plus4 = instr_valid ? (head.pc + STEP) : '0;

    assert property (@(posedge clk) disable iff (!rst) imem_rsp_valid |-> (inflight_q != '0));
    assert property (@(posedge clk) disable iff (!rst) drop_q <= inflight_q);
    assert property (@(posedge clk) disable iff (!rst) inflight_q <= CW'(DEPTH));

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: cycle table for reset/streaming/back-pressure plus
// hand sequences for redirects and mid-stream reset, against an in-order memory model.
module tb_fetch_queue;
    import riscv_fetch_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req_valid, imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        instr_valid, instr_ready;
    logic [31:0] instr, instr_pc, instr_pc_plus4;

    int n_checks = 0;
    int n_fail   = 0;

    fetch_queue #(
        .ADDRESS_WIDTH (32),
        .DATA_WIDTH    (32),
        .DEPTH         (4),
        .RESET_PC      (32'h100)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .redirect       (redirect),
        .redirect_pc    (redirect_pc),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .instr          (instr),
        .instr_pc       (instr_pc),
        .instr_pc_plus4 (instr_pc_plus4)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_data(input logic [31:0] a);
        return NOP ^ {a[19:0], 12'h000};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // In-order memory: response for a request accepted at edge c is driven from edge c+lat-1.
    typedef struct {
        logic [31:0] addr;
        int          due;
    } req_t;
    req_t q[$];
    int   cyc = 0;
    int   mem_lat = 1;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            q.delete();
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = '0;
        end else begin
            cyc++;
            if (imem_rsp_valid) void'(q.pop_front());
            if (imem_req_valid && imem_req_ready) q.push_back('{imem_req_addr, cyc + mem_lat - 1});
            #1;
            if (q.size() > 0 && q[0].due <= cyc) begin
                imem_rsp_valid = 1'b1;
                imem_rsp_data  = mem_data(q[0].addr);
            end else begin
                imem_rsp_valid = 1'b0;
                imem_rsp_data  = '0;
            end
        end
    end

    // Every presented instruction must carry its own PC's data; log consumed PCs.
    logic [31:0] log_pc[$];
    always @(posedge clk) begin
        if (rst && instr_valid) begin
            check("head data", instr, mem_data(instr_pc));
            check("pc_plus4", instr_pc_plus4, instr_pc + 32'd4);
            if (instr_ready) log_pc.push_back(instr_pc);
        end
    end

    typedef struct {
        logic        rst;
        logic        rdy;
        logic        rv;
        logic [31:0] addr;
        logic        iv;
        logic [31:0] pc;
    } vec_t;
    vec_t vecs[$];

    task automatic add(input logic r, input logic rdy, input logic rv, input logic [31:0] addr,
                       input logic iv, input logic [31:0] pc);
        vecs.push_back('{r, rdy, rv, addr, iv, pc});
    endtask

    task automatic do_reset(input int lat, input logic rdy);
        @(negedge clk);
        rst = 1'b0; redirect = 1'b0; instr_ready = rdy; mem_lat = lat;
        @(negedge clk);
        rst = 1'b1;
        #1;
    endtask

    task automatic wait_iv(input int max, input logic [31:0] exp_pc, input string name);
        int n = 0;
        while (!instr_valid && n < max) begin
            @(negedge clk); #1;
            n++;
        end
        check(name, instr_valid ? instr_pc : 32'hFFFF_FFFF, exp_pc);
    endtask

    logic [31:0] first_pc;

    initial begin
        rst = 1'b0; instr_ready = 1'b0; redirect = 1'b0; redirect_pc = '0;
        imem_req_ready = 1'b1;

        // Streaming at one per cycle
        add(0, 1, 0, 0, 0, 0);         add(0, 1, 0, 0, 0, 0);
        add(1, 1, 1, 32'h100, 0, 0);   add(1, 1, 1, 32'h104, 0, 0);
        add(1, 1, 1, 32'h108, 1, 32'h100);
        add(1, 1, 1, 32'h10C, 1, 32'h104);
        add(1, 1, 1, 32'h110, 1, 32'h108);
        add(1, 1, 1, 32'h114, 1, 32'h10C);
        // Mid-stream reset, then decode stalled until the queue fills, then released
        add(0, 0, 0, 0, 0, 0);         add(0, 0, 0, 0, 0, 0);
        add(1, 0, 1, 32'h100, 0, 0);   add(1, 0, 1, 32'h104, 0, 0);
        add(1, 0, 1, 32'h108, 1, 32'h100);
        add(1, 0, 1, 32'h10C, 1, 32'h100);
        add(1, 0, 0, 0, 1, 32'h100);   add(1, 0, 0, 0, 1, 32'h100);
        add(1, 1, 0, 0, 1, 32'h100);
        add(1, 1, 1, 32'h110, 1, 32'h104);
        add(1, 1, 1, 32'h114, 1, 32'h108);
        add(1, 1, 1, 32'h118, 1, 32'h10C);
        add(1, 1, 1, 32'h11C, 1, 32'h110);
        add(1, 1, 1, 32'h120, 1, 32'h114);

        foreach (vecs[i]) begin
            @(negedge clk);
            rst = vecs[i].rst; instr_ready = vecs[i].rdy;
            #1;
            check($sformatf("vec%0d req_valid", i), 32'(imem_req_valid), 32'(vecs[i].rv));
            if (vecs[i].rv) check($sformatf("vec%0d req_addr", i), imem_req_addr, vecs[i].addr);
            check($sformatf("vec%0d instr_valid", i), 32'(instr_valid), 32'(vecs[i].iv));
            if (vecs[i].iv) check($sformatf("vec%0d instr_pc", i), instr_pc, vecs[i].pc);
            if (!vecs[i].rst) begin
                check($sformatf("vec%0d rst instr", i), instr, 32'h0);
                check($sformatf("vec%0d rst pc", i), instr_pc, 32'h0);
                check($sformatf("vec%0d rst pc_plus4", i), instr_pc_plus4, 32'h0);
            end
        end

        // Redirect coincident with a response and a pop
        @(negedge clk);
        log_pc.delete();
        redirect = 1'b1; redirect_pc = 32'h302;
        #1;
        check("t4 req suppressed", 32'(imem_req_valid), 32'h0);
        check("t4 head pc", instr_pc, 32'h118);
        @(negedge clk);
        redirect = 1'b0;
        #1;
        check("t4 instr_valid after", 32'(instr_valid), 32'h0);
        check("t4 req_valid", 32'(imem_req_valid), 32'h1);
        check("t4 req_addr", imem_req_addr, 32'h300);
        wait_iv(10, 32'h300, "t4 first pc");
        first_pc = (log_pc.size() > 0) ? log_pc[0] : 32'hFFFF_FFFF;
        check("t4 pops", 32'(log_pc.size()), 32'h1);
        check("t4 popped pc", first_pc, 32'h118);

        // Latency 3, two in flight, redirect to an unaligned PC
        do_reset(3, 1'b1);
        @(negedge clk);
        @(negedge clk);
        redirect = 1'b1; redirect_pc = 32'h203;
        #1;
        check("t3 req suppressed", 32'(imem_req_valid), 32'h0);
        @(negedge clk);
        redirect = 1'b0;
        #1;
        check("t3 req_valid", 32'(imem_req_valid), 32'h1);
        check("t3 req_addr", imem_req_addr, 32'h200);
        check("t3 instr_valid", 32'(instr_valid), 32'h0);
        wait_iv(20, 32'h200, "t3 first pc");

        // Back-to-back redirects with three in flight
        do_reset(3, 1'b1);
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        redirect = 1'b1; redirect_pc = 32'h400;
        #1;
        check("t5 req suppressed 1", 32'(imem_req_valid), 32'h0);
        @(negedge clk);
        redirect_pc = 32'h800;
        #1;
        check("t5 req suppressed 2", 32'(imem_req_valid), 32'h0);
        check("t5 instr_valid", 32'(instr_valid), 32'h0);
        @(negedge clk);
        redirect = 1'b0;
        #1;
        check("t5 req_addr", imem_req_addr, 32'h800);
        check("t5 req_valid", 32'(imem_req_valid), 32'h1);
        wait_iv(20, 32'h800, "t5 first pc");

        // Reset with three buffered entries
        do_reset(1, 1'b0);
        repeat (4) @(negedge clk);
        #1;
        check("t6 pre instr_pc", instr_pc, 32'h100);
        check("t6 pre req_valid", 32'(imem_req_valid), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("t6 rst instr_valid", 32'(instr_valid), 32'h0);
        check("t6 rst req_valid", 32'(imem_req_valid), 32'h0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("t6 restart req_valid", 32'(imem_req_valid), 32'h1);
        check("t6 restart addr", imem_req_addr, 32'h100);
        wait_iv(5, 32'h100, "t6 restart pc");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
